moving_average_filter: RTL

- Consumes the 10-bit noisy sine sample stream (ROM sine + noise generator sum) and outputs its boxcar moving average over the last 2^LOG2_N samples.
- Sits downstream of the signal source; valid/ready on both sides so it can be paced by the source counter or stalled by a downstream sink.
- Circular sample buffer plus running sum; one output per accepted sample once the window is full.

---
 rtl/moving_average_filter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
//  Module   : moving_average_filter
//  Purpose  : Boxcar moving average over the last 2^LOG2_N unsigned samples.
//             A circular sample buffer and a running sum give one average per
//             accepted sample once the window is full. Valid/ready handshakes
//             on both sides, with a single output register and no bubble.
//  Options  : ROUND_EN - when defined, the average is rounded half-up and
//             saturated; otherwise it is truncated.
//  Revision : 1.0 - initial release
// ============================================================================
module moving_average_filter #(
  parameter int DATA_W = 10,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              filled
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  // Count value whose accept completes the window.
  localparam logic [LOG2_N:0] LAST_FILL = (LOG2_N + 1)'(N - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [LOG2_N:0]     count;
  logic [LOG2_N-1:0]   wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [DATA_W-1:0]   sample_mem [N];

  logic                accept;
  logic                produce;
  logic [DATA_W-1:0]   oldest;
  logic [SUM_W-1:0]    sum_next;
  logic [DATA_W-1:0]   avg_next;

  // The sink-side register frees up when empty or being drained this cycle;
  // reset and flush block intake so no sample slips past a clear.
  assign in_ready = reset && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // While filling, the slot being overwritten holds no window sample, so it
  // must not be subtracted from the running sum.
  assign oldest   = (state == RUN) ? sample_mem[wr_ptr] : '0;

  // The oldest sample is always part of sum, so the difference never goes
  // negative and the extra LOG2_N bits cover N full-scale samples.
  assign sum_next = sum + {{LOG2_N{1'b0}}, in_data} - {{LOG2_N{1'b0}}, oldest};

  // An output is produced by every accept in RUN and by the accept that
  // completes the window.
  assign produce  = accept && ((state == RUN) || (count == LAST_FILL));

`ifdef ROUND_EN
  localparam logic [SUM_W:0] HALF    = (SUM_W + 1)'(1) << (LOG2_N - 1);
  localparam logic [SUM_W:0] MAX_AVG = {{(SUM_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [SUM_W:0] round_sum;
  logic [SUM_W:0] round_shift;

  // Round half-up with one bit of headroom, then clamp to full scale.
  assign round_sum   = {1'b0, sum_next} + HALF;
  assign round_shift = round_sum >> LOG2_N;
  assign avg_next    = (round_shift > MAX_AVG) ? {DATA_W{1'b1}}
                                               : round_shift[DATA_W-1:0];
`else
  // Plain truncating divide by N.
  assign avg_next    = sum_next[SUM_W-1:LOG2_N];
`endif

  assign filled = (state == RUN);

  // Sample buffer write; contents need no reset because FILL never reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      sample_mem[wr_ptr] <= in_data;
    end
  end

  // Window control, running sum and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      count     <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= FILL;
      count     <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        sum    <= sum_next;
        wr_ptr <= wr_ptr + 1'b1;
        if (state == FILL) begin
          count <= count + 1'b1;
          if (count == LAST_FILL) begin
            state <= RUN;
          end
        end
      end

      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= avg_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
